// File: rtl/inst_mem.sv
// inst_mem: instruction ROM with a byte-serial boot loader.
// Optional fetch address check: define INST_MEM_ADDR_CHK_EN.
module inst_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic [31:0]       inst,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              boot_done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   wr_ptr;
  logic [31:0]       asm_q;
  logic [31:0]       asm_nxt;
  logic              accept;
  logic              commit;
  logic              rd_en;
  logic              illegal;
  logic [ADDR_W-1:0] rd_idx;

  logic [31:0] mem [DEPTH];

  always_comb begin
    accept    = 1'b0;
    commit    = 1'b0;
    asm_nxt   = asm_q;
    state_nxt = state;
    unique case (state)
      LOAD: begin
        accept  = load_valid;
        commit  = load_valid
                & ((byte_cnt == 2'd3) | load_last);
        // big-endian: byte 0 lands in [31:24]
        asm_nxt = asm_q
                | ({24'b0, load_data} << {~byte_cnt, 3'b000});
        if (commit
            && (load_last || wr_ptr == LAST_PTR))
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= LOAD;
      byte_cnt <= 2'd0;
      wr_ptr   <= '0;
      asm_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (commit) begin
          wr_ptr   <= wr_ptr + 1'b1;
          byte_cnt <= 2'd0;
          asm_q    <= '0;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_q    <= asm_nxt;
        end
      end
    end
  end

  // array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (rst && commit)
      mem[wr_ptr[ADDR_W-1:0]] <= asm_nxt;
  end

  assign load_ready = (state == LOAD);
  assign boot_done  = (state == DONE);
  assign word_cnt   = wr_ptr;
  assign rd_en      = ce & boot_done;
  assign rd_idx     = addr[ADDR_W+1:2];

`ifdef INST_MEM_ADDR_CHK_EN
  logic err_q;

  assign illegal = rd_en
                 & ((|addr[1:0]) | (|addr[31:ADDR_W+2]));

  always_ff @(posedge clk) begin
    if (!rst)
      err_q <= 1'b0;
    else if (illegal)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_addr;

  assign illegal     = 1'b0;
  assign err         = 1'b0;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
`endif

  assign inst = (rd_en && !illegal) ? mem[rd_idx] : 32'h0;

endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: directed bench for inst_mem, ADDR_W=10 and ADDR_W=2
// side by side on shared stimulus, checked against a byte-stream model.
module tb_inst_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'h0;
  logic        load_last = 1'b0;

  logic [31:0] inst_b, inst_s;
  logic        rdy_b, rdy_s, done_b, done_s, err_b, err_s;
  logic [10:0] wc_b;
  logic [2:0]  wc_s;

  int total = 0;
  int bad = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  inst_mem #(.ADDR_W(10)) u_big (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
    .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(rdy_b),
    .boot_done(done_b), .word_cnt(wc_b), .err(err_b)
  );

  inst_mem #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_s),
    .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(rdy_s),
    .boot_done(done_s), .word_cnt(wc_s), .err(err_s)
  );

  // model state, index 0 = ADDR_W 10, index 1 = ADDR_W 2
  int unsigned m_mem [2][1024];
  bit          m_wr  [2][1024];
  bit          m_done[2];
  bit          m_err [2];
  int          m_ptr [2];
  int          m_n   [2];
  int unsigned m_acc [2];

  function automatic int depth(int u);
    return (u == 0) ? 1024 : 4;
  endfunction

  function automatic int aw(int u);
    return (u == 0) ? 10 : 2;
  endfunction

  function automatic bit bad_addr(int u);
`ifdef INST_MEM_ADDR_CHK_EN
    return (addr[1:0] != 2'b0) || ((addr >> (2 + aw(u))) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 1024; k++) begin
        m_wr[u][k] = 1'b0;
        m_mem[u][k] = 0;
      end
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst) begin
        m_done[u] = 1'b0;
        m_err[u]  = 1'b0;
        m_ptr[u]  = 0;
        m_n[u]    = 0;
        m_acc[u]  = 0;
      end else begin
        if (m_done[u] && ce && bad_addr(u))
          m_err[u] = 1'b1;
        if (!m_done[u] && load_valid) begin
          m_acc[u] = (m_acc[u] << 8) | 32'(load_data);
          m_n[u]++;
          if (m_n[u] == 4 || load_last) begin
            m_mem[u][m_ptr[u]] = m_acc[u] << (8 * (4 - m_n[u]));
            m_wr[u][m_ptr[u]] = 1'b1;
            m_ptr[u]++;
            m_n[u] = 0;
            m_acc[u] = 0;
            if (load_last || m_ptr[u] == depth(u))
              m_done[u] = 1'b1;
          end
        end
      end
    end
    if (!rst) armed = 1'b1;
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        logic [31:0] d_inst;
        logic        d_rdy, d_done, d_err;
        int          d_wc, idx;
        bit          known;
        logic [31:0] e_inst;
        d_inst = (u == 0) ? inst_b : inst_s;
        d_rdy  = (u == 0) ? rdy_b : rdy_s;
        d_done = (u == 0) ? done_b : done_s;
        d_err  = (u == 0) ? err_b : err_s;
        d_wc   = (u == 0) ? int'(wc_b) : int'(wc_s);
        idx    = int'((addr >> 2) % depth(u));
        known  = 1'b1;
        e_inst = 32'h0;
        if (ce && m_done[u] && !bad_addr(u)) begin
          known  = m_wr[u][idx];
          e_inst = m_mem[u][idx];
        end
        check($sformatf("cyc_rdy%0d", u), 64'(d_rdy), 64'(!m_done[u]));
        check($sformatf("cyc_done%0d", u), 64'(d_done), 64'(m_done[u]));
        check($sformatf("cyc_wc%0d", u), 64'(d_wc), 64'(m_ptr[u]));
        check($sformatf("cyc_err%0d", u), 64'(d_err), 64'(m_err[u]));
        if (known)
          check($sformatf("cyc_inst%0d", u), 64'(d_inst), 64'(e_inst));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] d, logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic fetch(logic [31:0] a, logic c);
    addr = a;
    ce   = c;
    @(negedge clk);
  endtask

  logic [7:0] prog [8];

  initial begin
    prog[0] = 8'h34; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h01;
    prog[4] = 8'h34; prog[5] = 8'h02; prog[6] = 8'h00; prog[7] = 8'h02;

    do_reset();
    fetch(32'h0, 1'b1);
    check("rst_ready", 64'(rdy_b), 64'd1);
    check("rst_done", 64'(done_b), 64'd0);
    check("rst_wc", 64'(wc_b), 64'd0);
    check("rst_inst", 64'(inst_b), 64'd0);
    check("rst_err", 64'(err_b), 64'd0);
    step();

    // two-word program, load_last on byte 8
    for (int i = 0; i < 8; i++) send(prog[i], i == 7);
    fetch(32'h0, 1'b1);
    check("p_wc", 64'(wc_b), 64'd2);
    check("p_done", 64'(done_b), 64'd1);
    check("p_ready", 64'(rdy_b), 64'd0);
    check("p_w0", 64'(inst_b), 64'h34010001);
    step();
    fetch(32'h4, 1'b1);
    check("p_w1", 64'(inst_b), 64'h34020002);
    check("p_w1s", 64'(inst_s), 64'h34020002);
    step();
    fetch(32'h4, 1'b0);
    check("p_ce0", 64'(inst_b), 64'h0);
    step();
    send(8'hEE, 1'b1);
    fetch(32'h4, 1'b1);
    check("p_ignore_wc", 64'(wc_b), 64'd2);
    check("p_ignore_w1", 64'(inst_b), 64'h34020002);
    step();

    // short final word padded with zeros
    ce = 1'b0;
    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    fetch(32'h0, 1'b1);
    check("s_w0", 64'(inst_b), 64'hAABBCC00);
    check("s_wc", 64'(wc_b), 64'd1);
    check("s_w0s", 64'(inst_s), 64'hAABBCC00);
    step();

    // stream 20 bytes, no load_last: small memory fills after 16
    ce = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h10 + i), 1'b0);
      if (i == 14) begin
        @(negedge clk);
        check("f_pre_done", 64'(done_s), 64'd0);
        step();
      end
      if (i == 15) begin
        @(negedge clk);
        check("f_done_at16", 64'(done_s), 64'd1);
        step();
      end
    end
    fetch(32'h0, 1'b1);
    check("f_wc_s", 64'(wc_s), 64'd4);
    check("f_done_s", 64'(done_s), 64'd1);
    check("f_w0_s", 64'(inst_s), 64'h10111213);
    check("f_wc_b", 64'(wc_b), 64'd5);
    check("f_done_b", 64'(done_b), 64'd0);
    check("f_inst_b", 64'(inst_b), 64'h0);
    step();

    // reset after 6 bytes, one byte offered during reset
    ce = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) send(8'(8'h51 + i), 1'b0);
    rst = 1'b0;
    send(8'h99, 1'b0);
    rst = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    fetch(32'h0, 1'b1);
    check("r_w0", 64'(inst_b), 64'h11223344);
    check("r_wc", 64'(wc_b), 64'd1);
    step();
    fetch(32'h4, 1'b1);
    check("r_w1_old", 64'(inst_b), 64'h14151617);
    check("r_w1_old_s", 64'(inst_s), 64'h14151617);
    step();

    // misaligned and out-of-range fetches
    fetch(32'h2, 1'b1);
`ifdef INST_MEM_ADDR_CHK_EN
    check("a_mis_inst", 64'(inst_b), 64'h0);
    check("a_mis_err0", 64'(err_b), 64'd0);
    step();
    fetch(32'h0, 1'b1);
    check("a_err_set", 64'(err_b), 64'd1);
    check("a_legal", 64'(inst_b), 64'h11223344);
    step();
    fetch(32'h1000, 1'b1);
    check("a_hi_inst", 64'(inst_b), 64'h0);
    check("a_err_keep", 64'(err_b), 64'd1);
    step();
`else
    check("a_mis_inst", 64'(inst_b), 64'h11223344);
    check("a_err_zero", 64'(err_b), 64'd0);
    step();
    fetch(32'h1000, 1'b1);
    check("a_alias_b", 64'(inst_b), 64'h11223344);
    check("a_alias_s", 64'(inst_s), 64'h11223344);
    check("a_err_zero2", 64'(err_b), 64'd0);
    step();
`endif

    ce = 1'b0;
    step();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem.md
# inst_mem

Instruction memory responder on the CPU's instruction fetch port. It answers the core's `rom_ce_o`/`rom_addr_o` with a 32-bit instruction on `rom_data_i` in the same cycle. Before the core runs, a byte-serial boot loader fills the memory. The block sits beside the CPU top in the SoC wrapper, and `boot_done` gates the CPU out of reset once the program is loaded.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width. Depth is 2^ADDR_W 32-bit words.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst==0` resets).
- `ce`  in  1  fetch enable from the core (`1` = ChipEnable).
- `addr`  in  32  fetch byte address from the core.
- `inst`  out  32  instruction to the core; combinational.
- `load_valid`  in  1  boot byte present.
- `load_data`  in  8  boot byte.
- `load_last`  in  1  marks the final boot byte; qualified by `load_valid`.
- `load_ready`  out  1  loader accepts bytes.
- `boot_done`  out  1  program loaded; fetch port live.
- `word_cnt`  out  ADDR_W+1  number of words written since reset.
- `err`  out  1  sticky address error. Exists only with the macro described under Configuration; otherwise tied to 0.

## Operation
- Storage: 2^ADDR_W × 32 array. It is not cleared by reset, so contents survive a reset.
- Fetch:
  - Word index is `addr[ADDR_W+1:2]`.
  - `inst = mem[index]` when `ce==1` and `boot_done==1`; otherwise `inst = 0`.
- Loader FSM has two states, LOAD and DONE.
- LOAD:
  - `load_ready=1`.
  - Each cycle with `load_valid==1`, the byte is accepted into assembly register `asm[31:0]` at `byte_cnt` (0..3).
  - Byte order is big-endian: byte 0 goes to `[31:24]` and byte 3 goes to `[7:0]`.
- Word commit: happens when byte 3 is accepted, or when `load_last` is accepted at any `byte_cnt`.
  - The word is written to `mem[wr_ptr]`; bytes not yet received are zero.
  - Then `wr_ptr` increments, `byte_cnt` returns to 0, and `asm` clears.
- LOAD to DONE: on the commit carrying `load_last`, or on the commit to the last word `wr_ptr==2^ADDR_W-1` (memory full).
  - In the full case, `load_last` is not required.
  - If a full memory was committed without `load_last`, later bytes are dropped.
- DONE:
  - `load_ready=0`, `boot_done=1`, and `load_*` inputs are ignored.
  - Stays in DONE until reset.
- `word_cnt` equals `wr_ptr`. It saturates at 2^ADDR_W, which is why it is ADDR_W+1 bits wide.

## Timing
- Reset values (`rst==0` at an edge): state=LOAD, `byte_cnt=0`, `wr_ptr=0`, `asm=0`.
  - After reset: `load_ready=1`, `boot_done=0`, `word_cnt=0`, `inst=0`, `err=0`.
- Fetch latency is 0 cycles: `inst` follows `addr`/`ce` combinationally. The core's IF/ID stage registers it.
- Load throughput is one byte per cycle, and `load_valid` may stay high continuously.
- A committed word is readable from the cycle after the commit edge. `boot_done` rises on that same edge when the commit is final.
- Reset mid-load:
  - The partial word in `asm` is discarded.
  - `wr_ptr` returns to 0 and the next byte starts word 0 again.
  - Previously written words remain in the array.
- `load_valid` with `rst==0`: reset wins and the byte is dropped.
- `load_valid` while in DONE: no write, no counter change.

## Configuration
- `INST_MEM_ADDR_CHK_EN` defined:
  - An address is illegal when `ce==1`, `boot_done==1`, and either `addr[1:0]!=0` or `addr[31:ADDR_W+2]!=0`.
  - For an illegal address, `inst=0` that cycle and `err` is set at the next edge.
  - `err` stays set until reset.
- `INST_MEM_ADDR_CHK_EN` undefined:
  - No check is made and `err` is constant 0.
  - Upper address bits are ignored, so addresses alias modulo 4·2^ADDR_W.
  - Misaligned addresses read the containing word.

## Test plan
- Reset, then bytes 34 01 00 01 | 34 02 00 02 with `load_last` on the 8th byte:
  - `mem[0]=0x34010001`, `mem[1]=0x34020002`.
  - `word_cnt=2`, `boot_done=1` one edge after the 8th byte, `load_ready=0`.
- After loading, fetch `addr=0x4`, `ce=1`: `inst=0x34020002` in the same cycle. With `ce=0`, `inst=0`.
- Send 3 bytes AA BB CC with `load_last` on CC: `mem[0]=0xAABBCC00`, `word_cnt=1`.
- With `ADDR_W=2`, stream 20 bytes with no `load_last`:
  - `boot_done` rises after byte 16 and `word_cnt=4`.
  - Bytes 17–20 are ignored and `mem[0]` is unchanged.
- Reset asserted after 6 bytes, then reload 4 bytes 11 22 33 44 with `load_last`:
  - `mem[0]=0x11223344`, `word_cnt=1`.
  - `mem[1]` keeps its old contents; the partial word was never committed.
- With `INST_MEM_ADDR_CHK_EN` defined, after boot fetch `addr=0x2`:
  - `inst=0` that cycle and `err=1` from the next cycle on.
  - A later legal fetch returns data while `err` stays 1.
